// File: rtl/axi4_cfg_slave.sv
// -----------------------------------------------------------------------------
// axi4_cfg_slave
//
// AXI4 configuration register slave. Owns a bank of NR_OF_REGS_P registers,
// split into read/write configuration registers and read-only status slots
// (selected by RO_MASK_P). Supports byte-strobed single-beat writes,
// incrementing burst reads (arlen), a one-cycle write pulse per register and
// SLVERR responses for writes to read-only/out-of-range registers and for
// read beats past the end of the bank.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   aw*/w*/b*             write address/data/response channels
//   ar*/r*                read address/data channels (rid is constant 0)
//   cfg_regs              flattened register bank, slot i = register i
//   sts_regs              status inputs, only read-only slots are used
//   cfg_wr_pulse          one-cycle pulse per register on a successful write
// AXI4_DATA_WIDTH_P must be 32 or 64.
// -----------------------------------------------------------------------------
module axi4_cfg_slave #(
    parameter int AXI4_ID_WIDTH_P   = 2,
    parameter int AXI4_ADDR_WIDTH_P = 16,
    parameter int AXI4_DATA_WIDTH_P = 32,
    parameter int AXI4_STRB_WIDTH_P = AXI4_DATA_WIDTH_P / 8,
    parameter int NR_OF_REGS_P      = 8,
    parameter logic [NR_OF_REGS_P-1:0] RO_MASK_P = '0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              awaddr,
    input  logic                                      awvalid,
    output logic                                      awready,
    input  logic [AXI4_DATA_WIDTH_P-1:0]              wdata,
    input  logic [AXI4_STRB_WIDTH_P-1:0]              wstrb,
    input  logic                                      wlast,
    input  logic                                      wvalid,
    output logic                                      wready,
    output logic [1:0]                                bresp,
    output logic                                      bvalid,
    input  logic                                      bready,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              araddr,
    input  logic [7:0]                                arlen,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [AXI4_ID_WIDTH_P-1:0]                rid,
    output logic [AXI4_DATA_WIDTH_P-1:0]              rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready,
    output logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] cfg_regs,
    input  logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] sts_regs,
    output logic [NR_OF_REGS_P-1:0]                   cfg_wr_pulse
);

    localparam int DW     = AXI4_DATA_WIDTH_P;
    localparam int LSB_W  = $clog2(AXI4_STRB_WIDTH_P);
    localparam int IDX_W  = AXI4_ADDR_WIDTH_P - LSB_W;
    // One extra bit so a burst running past the bank never wraps back into it.
    localparam int RIDX_W = IDX_W + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]        wr_state;
    logic [0:0]        rd_state;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_ok;
    logic [RIDX_W-1:0] rd_idx;
    logic [RIDX_W-1:0] rd_idx_nxt;
    logic [RIDX_W-1:0] ar_idx;
    logic [7:0]        rd_len;
    logic [7:0]        rd_cnt;
    logic [7:0]        rd_cnt_nxt;
    logic [DW-1:0]     cfg_q [NR_OF_REGS_P];

    // Sub-word address bits and wlast carry no information for this slave.
    logic unused_ok;
    assign unused_ok = &{1'b0, wlast, awaddr[LSB_W-1:0], araddr[LSB_W-1:0]};

    function automatic logic is_writable(input logic [IDX_W-1:0] idx);
        is_writable = 1'b0;
        for (int i = 0; i < NR_OF_REGS_P; i++) begin
            if (idx == IDX_W'(i)) is_writable = !RO_MASK_P[i];
        end
    endfunction

    function automatic logic [DW-1:0] rd_word(input logic [RIDX_W-1:0] idx);
        rd_word = '0;
        for (int i = 0; i < NR_OF_REGS_P; i++) begin
            if (idx == RIDX_W'(i)) rd_word = RO_MASK_P[i] ? sts_regs[i*DW +: DW] : cfg_q[i];
        end
    endfunction

    function automatic logic [1:0] rd_resp(input logic [RIDX_W-1:0] idx);
        rd_resp = (idx < RIDX_W'(NR_OF_REGS_P)) ? RESP_OKAY : RESP_SLVERR;
    endfunction

    assign wr_ok      = is_writable(wr_idx);
    assign ar_idx     = {1'b0, araddr[AXI4_ADDR_WIDTH_P-1:LSB_W]};
    assign rd_idx_nxt = rd_idx + RIDX_W'(1);
    assign rd_cnt_nxt = rd_cnt + 8'd1;
    assign rid        = '0;

    for (genvar g = 0; g < NR_OF_REGS_P; g++) begin : g_flat
        assign cfg_regs[g*DW +: DW] = cfg_q[g];
    end

    // Write path: AW -> W -> B, one transaction at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state     <= W_IDLE;
            wr_idx       <= '0;
            awready      <= 1'b1;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            cfg_wr_pulse <= '0;
            for (int i = 0; i < NR_OF_REGS_P; i++) cfg_q[i] <= '0;
        end else begin
            cfg_wr_pulse <= '0;
            case (wr_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        wr_idx   <= awaddr[AXI4_ADDR_WIDTH_P-1:LSB_W];
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        wready   <= 1'b0;
                        bvalid   <= 1'b1;
                        bresp    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        wr_state <= W_RESP;
                        // Register update and pulse land on the same edge.
                        for (int i = 0; i < NR_OF_REGS_P; i++) begin
                            cfg_wr_pulse[i] <= wr_ok && (wr_idx == IDX_W'(i));
                            for (int b = 0; b < AXI4_STRB_WIDTH_P; b++) begin
                                if (wr_ok && (wr_idx == IDX_W'(i)) && wstrb[b])
                                    cfg_q[i][8*b +: 8] <= wdata[8*b +: 8];
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read path: each beat is captured into rdata/rresp/rlast at the edge it
    // is presented, so it holds while stalled and sees pre-write cfg values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready  <= 1'b0;
                        rd_idx   <= ar_idx;
                        rd_len   <= arlen;
                        rd_cnt   <= '0;
                        rvalid   <= 1'b1;
                        rdata    <= rd_word(ar_idx);
                        rresp    <= rd_resp(ar_idx);
                        rlast    <= (arlen == 8'd0);
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            rd_state <= R_IDLE;
                        end else begin
                            rd_idx <= rd_idx_nxt;
                            rd_cnt <= rd_cnt_nxt;
                            rdata  <= rd_word(rd_idx_nxt);
                            rresp  <= rd_resp(rd_idx_nxt);
                            rlast  <= (rd_cnt_nxt == rd_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_cfg_slave.md
Name: axi4_cfg_slave

Overview:
Parametrised AXI4 configuration register slave. It terminates one AXI4 configuration bus from a master-side controller and owns a bank of NR_OF_REGS_P registers. The bank is split into read/write configuration registers and read-only status registers. It adds behaviour a bare configuration interface lacks: byte-strobed writes, incrementing burst reads via arlen, per-register write pulses, and SLVERR responses for illegal accesses.

Parameters:
AXI4_ID_WIDTH_P, 2, width of rid.
AXI4_ADDR_WIDTH_P, 16, byte address width.
AXI4_DATA_WIDTH_P, 32, data width; must be 32 or 64.
AXI4_STRB_WIDTH_P, AXI4_DATA_WIDTH_P/8, strobe width.
NR_OF_REGS_P, 8, number of registers; register index = addr >> log2(AXI4_STRB_WIDTH_P).
RO_MASK_P, 0, NR_OF_REGS_P-bit mask; bit i set means register i is read-only and reads return sts_regs slot i.

Ports:
clk  in  1  clock
rst_n  in  1  reset
awaddr  in  AXI4_ADDR_WIDTH_P  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  AXI4_DATA_WIDTH_P  write data
wstrb  in  AXI4_STRB_WIDTH_P  byte strobes
wlast  in  1  ignored; writes are single-beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response (00 OKAY, 10 SLVERR)
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  AXI4_ADDR_WIDTH_P  read start address
arlen  in  8  burst length minus one
arvalid  in  1  read address valid
arready  out  1  read address ready
rid  out  AXI4_ID_WIDTH_P  constant 0
rdata  out  AXI4_DATA_WIDTH_P  read data
rresp  out  2  read response per beat
rlast  out  1  last beat
rvalid  out  1  read valid
rready  in  1  read ready
cfg_regs  out  NR_OF_REGS_P*AXI4_DATA_WIDTH_P  flattened register bank; slot i = register i
sts_regs  in  NR_OF_REGS_P*AXI4_DATA_WIDTH_P  status inputs; only read-only slots are used
cfg_wr_pulse  out  NR_OF_REGS_P  one-cycle pulse per register on a successful write

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - awready=1, wready=0, bvalid=0, bresp=0.
  - arready=1, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0.
  - cfg_regs all 0, cfg_wr_pulse=0.
  - Reset mid-transaction aborts it; both state machines return to IDLE.
- Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
  - W_IDLE: awready=1. On awvalid, latch the register index, set awready=0 and wready=1, go to W_DATA.
  - W_DATA: on wvalid&&wready, set wready=0.
    - If the index is in range and not read-only: for each strobe bit set, update the corresponding byte lane of cfg_regs[idx]. cfg_wr_pulse[idx]=1 for exactly one cycle, the same cycle the register updates. bresp=OKAY.
    - Otherwise: no register change, no pulse, bresp=SLVERR.
  - W_DATA continued: bvalid=1 the cycle after the W handshake; go to W_RESP.
  - W_RESP: hold bvalid/bresp until bready. Then bvalid=0, awready=1 next cycle.
  - A write with wstrb=0 updates no bytes but still pulses and returns OKAY.
- Read FSM (R_IDLE -> R_DATA -> R_IDLE):
  - R_IDLE: arready=1. On arvalid, latch the start index and arlen, set arready=0, clear the beat counter.
  - R_DATA: rvalid=1 the cycle after the AR handshake (1-cycle latency).
  - Beat k reads index start+k.
    - Read-only slots return sts_regs; other slots return cfg_regs.
    - If the index is >= NR_OF_REGS_P: rdata=0 and rresp=SLVERR for that beat only.
    - The index counter saturates at neither end; it increments as a full counter, so indices past the bank end are errors.
  - rlast=1 when the beat count equals arlen.
  - rdata/rresp/rlast are stable while rvalid&&!rready.
  - Next beat is presented the cycle after each rvalid&&rready.
  - After the last beat: rvalid=0, arready=1 next cycle.
- Read and write paths are independent and may be active simultaneously.
  - A read beat of a register written in the same cycle returns the pre-write value.
  - A status slot always reflects sts_regs sampled in the beat-presentation cycle.
- Address bits below log2(AXI4_STRB_WIDTH_P) are ignored; unaligned accesses map to the containing register.
- No ID tracking; at most one outstanding read and one outstanding write.

Test Plan (defaults, RO_MASK_P=8'h80):
- Write 0xDEADBEEF to 0x0004, wstrb=4'hF -> bresp=OKAY; cfg_regs slot1=0xDEADBEEF; cfg_wr_pulse=8'h02 for one cycle.
- Write 0x11223344 to 0x0004, wstrb=4'h3 -> slot1=0xDEAD3344.
- Write to 0x001C (read-only slot7) or 0x0020 (index 8) -> bresp=SLVERR, no pulse, cfg_regs unchanged.
- Burst read araddr=0x0000, arlen=3, after writing slots0-3 with 0xA0..0xA3 -> 4 beats 0xA0,0xA1,0xA2,0xA3, OKAY, rlast only on beat 4.
- Burst read araddr=0x0018, arlen=2, sts slot7=0x55 -> beats: slot6 OKAY; 0x55 OKAY; 0 SLVERR with rlast. With rready toggled 1010, data must be held while stalled.
- Reset asserted while bvalid=1 and mid-burst -> all outputs at reset values; the next transaction completes normally.
